// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bundle: RAM read port, decoder handshake, redirect and halt
interface fetch_unit_if;
  logic [7:0] mem_addr;
  logic       mem_rEN;
  logic       mem_wEN;
  logic [7:0] mem_rdata;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_opcode;
  logic [7:0] instr_operand;
  logic [7:0] instr_pc;
  logic       jump_en;
  logic [7:0] jump_addr;
  logic       halt;

  // Fetch unit side
  modport master (
    output mem_addr, mem_rEN, mem_wEN,
    input  mem_rdata,
    output instr_valid, instr_opcode, instr_operand, instr_pc,
    input  instr_ready,
    input  jump_en, jump_addr, halt
  );

  // RAM / decoder / execute side
  modport slave (
    input  mem_addr, mem_rEN, mem_wEN,
    output mem_rdata,
    input  instr_valid, instr_opcode, instr_operand, instr_pc,
    output instr_ready,
    output jump_en, jump_addr, halt
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: owns the PC, reads 1/2-byte instructions, presents them to decode
module fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         LONG_BIT = 7
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_RESET,
    S_OP_REQ,
    S_OP_CAP,
    S_ARG_REQ,
    S_ARG_CAP,
    S_VALID
  } state_t;

  state_t     r_state;
  logic [7:0] r_pc;
  logic       r_valid;
  logic [7:0] r_opcode;
  logic [7:0] r_operand;
  logic [7:0] r_instr_pc;
  logic       w_rd_en;

  // Reads are issued only from the two request states; halt holds off only a new opcode read.
  assign w_rd_en = ((r_state == S_OP_REQ) && !bus.halt) || (r_state == S_ARG_REQ);

  assign bus.mem_addr      = r_pc;
  assign bus.mem_rEN       = w_rd_en;
  assign bus.mem_wEN       = 1'b0;
  assign bus.instr_valid   = r_valid;
  assign bus.instr_opcode  = r_opcode;
  assign bus.instr_operand = r_operand;
  assign bus.instr_pc      = r_instr_pc;

  // Fetch sequencer: a redirect overrides every state except S_RESET and drops any partial instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_RESET;
      r_pc       <= RESET_PC;
      r_valid    <= 1'b0;
      r_opcode   <= 8'h00;
      r_operand  <= 8'h00;
      r_instr_pc <= 8'h00;
    end else if (bus.jump_en && (r_state != S_RESET)) begin
      r_pc    <= bus.jump_addr;
      r_state <= S_OP_REQ;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_RESET: begin
          r_state <= S_OP_REQ;
        end
        S_OP_REQ: begin
          if (!bus.halt) begin
            r_instr_pc <= r_pc;
            r_state    <= S_OP_CAP;
          end
        end
        S_OP_CAP: begin
          r_opcode <= bus.mem_rdata;
          r_pc     <= r_pc + 8'd1;
          if (bus.mem_rdata[LONG_BIT]) begin
            r_state <= S_ARG_REQ;
          end else begin
            r_operand <= 8'h00;
            r_valid   <= 1'b1;
            r_state   <= S_VALID;
          end
        end
        S_ARG_REQ: begin
          r_state <= S_ARG_CAP;
        end
        S_ARG_CAP: begin
          r_operand <= bus.mem_rdata;
          r_pc      <= r_pc + 8'd1;
          r_valid   <= 1'b1;
          r_state   <= S_VALID;
        end
        S_VALID: begin
          if (bus.instr_ready) begin
            r_valid <= 1'b0;
            r_state <= S_OP_REQ;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_RESET;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed table, corner sequences and randomized scoreboard for fetch_unit
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(8'h00), .LONG_BIT(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 256-byte RAM with registered read data
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (bus.mem_rEN) bus.mem_rdata <= ram[bus.mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] exp_op;
    logic [7:0] exp_opnd;
    logic [7:0] exp_pc;
    int         exp_lat;
    logic [7:0] exp_next;
  } vec_t;

  vec_t vecs [6];

  // Reference: the instruction that starts at address a, from the RAM contents alone
  function automatic logic [23:0] ref_instr(input logic [7:0] a);
    logic [7:0] op;
    logic [7:0] a1;
    a1 = a + 8'd1;
    op = ram[a];
    return {op, (op[7] ? ram[a1] : 8'h00), a};
  endfunction

  function automatic logic [7:0] ref_len(input logic [7:0] a);
    logic [7:0] op;
    op = ram[a];
    return op[7] ? 8'd2 : 8'd1;
  endfunction

  // Wait up to 20 cycles for instr_valid; returns cycles waited and whether it was seen
  task automatic wait_valid(output int lat, output int found);
    lat = 0;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      tick();
      smp();
      lat++;
      if (bus.instr_valid) found = 1;
    end
  endtask

  initial begin
    int lat;
    int found;
    int hs;
    logic [7:0] m_pc;
    logic [7:0] a1;
    logic        prev_hold;
    logic [24:0] prev_vals;
    logic [23:0] exp_i;

    vecs[0] = '{8'h00, 8'h12, 8'h34, 8'h12, 8'h00, 8'h00, 2, 8'h01};
    vecs[1] = '{8'h00, 8'h85, 8'hAB, 8'h85, 8'hAB, 8'h00, 4, 8'h02};
    vecs[2] = '{8'hFF, 8'h90, 8'h07, 8'h90, 8'h07, 8'hFF, 4, 8'h01};
    vecs[3] = '{8'h7E, 8'h7F, 8'h55, 8'h7F, 8'h00, 8'h7E, 2, 8'h7F};
    vecs[4] = '{8'h30, 8'hC0, 8'h00, 8'hC0, 8'h00, 8'h30, 4, 8'h32};
    vecs[5] = '{8'hFF, 8'h01, 8'h99, 8'h01, 8'h00, 8'hFF, 2, 8'h00};

    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    rst = 1'b1;
    bus.instr_ready = 1'b0;
    bus.jump_en = 1'b0;
    bus.jump_addr = 8'h00;
    bus.halt = 1'b0;

    // Reset state, with jump and halt asserted to show reset wins
    tick();
    bus.jump_en = 1'b1;
    bus.jump_addr = 8'h55;
    bus.halt = 1'b1;
    tick();
    smp();
    chk("rst_ren", bus.mem_rEN, 1'b0);
    chk("rst_wen", bus.mem_wEN, 1'b0);
    chk("rst_addr", bus.mem_addr, 8'h00);
    chk("rst_out", {bus.instr_valid, bus.instr_opcode, bus.instr_operand, bus.instr_pc}, 25'h0);
    tick();
    rst = 1'b0;
    bus.jump_en = 1'b0;
    bus.halt = 1'b0;
    smp();
    chk("post_rst_sreset_ren", bus.mem_rEN, 1'b0);
    tick();
    smp();
    chk("first_req", {bus.mem_rEN, bus.mem_addr}, {1'b1, 8'h00});

    // Table-driven single instructions reached by redirect, ready held high
    for (int i = 0; i < 6; i++) begin
      a1 = vecs[i].addr + 8'd1;
      ram[vecs[i].addr] = vecs[i].b0;
      ram[a1] = vecs[i].b1;
      tick();
      bus.jump_en = 1'b1;
      bus.jump_addr = vecs[i].addr;
      bus.instr_ready = 1'b1;
      smp();
      tick();
      bus.jump_en = 1'b0;
      smp();
      chk($sformatf("vec%0d_req", i), {bus.mem_rEN, bus.mem_addr, bus.instr_valid}, {1'b1, vecs[i].addr, 1'b0});
      wait_valid(lat, found);
      chk($sformatf("vec%0d_found", i), found, 1);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_instr", i), {bus.instr_opcode, bus.instr_operand, bus.instr_pc},
          {vecs[i].exp_op, vecs[i].exp_opnd, vecs[i].exp_pc});
      tick();
      smp();
      chk($sformatf("vec%0d_next", i), {bus.mem_rEN, bus.mem_addr}, {1'b1, vecs[i].exp_next});
    end

    // Redirect during S_ARG_CAP drops the partial long instruction
    ram[8'h50] = 8'h85;
    ram[8'h51] = 8'hAB;
    ram[8'h40] = 8'h12;
    tick();
    bus.jump_en = 1'b1;
    bus.jump_addr = 8'h50;
    smp();
    tick();
    bus.jump_en = 1'b0;
    smp();
    chk("jarg_req", {bus.mem_rEN, bus.mem_addr}, {1'b1, 8'h50});
    tick();
    smp();
    tick();
    smp();
    chk("jarg_argreq", {bus.mem_rEN, bus.mem_addr}, {1'b1, 8'h51});
    tick();
    bus.jump_en = 1'b1;
    bus.jump_addr = 8'h40;
    smp();
    tick();
    bus.jump_en = 1'b0;
    smp();
    chk("jarg_redirect", {bus.mem_rEN, bus.mem_addr, bus.instr_valid}, {1'b1, 8'h40, 1'b0});
    wait_valid(lat, found);
    chk("jarg_found", found, 1);
    chk("jarg_instr", {bus.instr_opcode, bus.instr_operand, bus.instr_pc}, {8'h12, 8'h00, 8'h40});

    // Back-pressure: outputs frozen and no reads while ready is low
    ram[8'h60] = 8'hA5;
    ram[8'h61] = 8'h3C;
    ram[8'h62] = 8'h05;
    tick();
    bus.instr_ready = 1'b0;
    bus.jump_en = 1'b1;
    bus.jump_addr = 8'h60;
    smp();
    tick();
    bus.jump_en = 1'b0;
    smp();
    wait_valid(lat, found);
    chk("bp_found", found, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      smp();
      chk($sformatf("bp_hold%0d", k),
          {bus.instr_valid, bus.mem_rEN, bus.instr_opcode, bus.instr_operand, bus.instr_pc},
          {1'b1, 1'b0, 8'hA5, 8'h3C, 8'h60});
    end
    tick();
    bus.instr_ready = 1'b1;
    smp();
    tick();
    bus.instr_ready = 1'b0;
    smp();
    chk("bp_restart", {bus.mem_rEN, bus.mem_addr}, {1'b1, 8'h62});

    // Halt raised before S_OP_REQ: no reads; a redirect moves pc; release resumes there
    wait_valid(lat, found);
    chk("halt_found", found, 1);
    tick();
    bus.halt = 1'b1;
    bus.instr_ready = 1'b1;
    smp();
    tick();
    bus.instr_ready = 1'b0;
    smp();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("halt_idle%0d", k), {bus.mem_rEN, bus.instr_valid}, 2'b00);
      tick();
      smp();
    end
    tick();
    bus.jump_en = 1'b1;
    bus.jump_addr = 8'h20;
    smp();
    tick();
    bus.jump_en = 1'b0;
    smp();
    chk("halt_jump", {bus.mem_rEN, bus.mem_addr}, {1'b0, 8'h20});
    tick();
    bus.halt = 1'b0;
    smp();
    chk("halt_release", {bus.mem_rEN, bus.mem_addr}, {1'b1, 8'h20});

    // Reset during S_OP_CAP abandons the fetch and restarts at RESET_PC
    ram[8'h70] = 8'h11;
    tick();
    bus.jump_en = 1'b1;
    bus.jump_addr = 8'h70;
    smp();
    tick();
    bus.jump_en = 1'b0;
    smp();
    chk("rcap_req", {bus.mem_rEN, bus.mem_addr}, {1'b1, 8'h70});
    tick();
    rst = 1'b1;
    smp();
    tick();
    rst = 1'b0;
    smp();
    chk("rcap_out", {bus.instr_valid, bus.mem_rEN, bus.mem_addr, bus.instr_opcode}, {1'b0, 1'b0, 8'h00, 8'h00});
    tick();
    smp();
    chk("rcap_resume", {bus.mem_rEN, bus.mem_addr}, {1'b1, 8'h00});

    // Randomized run against the instruction-stream model
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    tick();
    rst = 1'b1;
    smp();
    tick();
    rst = 1'b0;
    smp();
    m_pc = 8'h00;
    hs = 0;
    prev_hold = 1'b0;
    prev_vals = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      bus.instr_ready = ($urandom % 10) < 7;
      bus.halt = ($urandom % 10) == 0;
      bus.jump_en = ($urandom % 32) == 0;
      bus.jump_addr = 8'($urandom);
      smp();
      if (bus.mem_wEN !== 1'b0) chk("rnd_wen", bus.mem_wEN, 1'b0);
      if (prev_hold)
        chk("rnd_hold", {bus.instr_valid, bus.instr_opcode, bus.instr_operand, bus.instr_pc}, prev_vals);
      if (bus.instr_valid) begin
        if (bus.mem_rEN !== 1'b0) chk("rnd_ren_while_valid", bus.mem_rEN, 1'b0);
      end
      if (bus.instr_valid && bus.instr_ready) begin
        exp_i = ref_instr(m_pc);
        chk("rnd_instr", {bus.instr_opcode, bus.instr_operand, bus.instr_pc}, exp_i);
        m_pc = m_pc + ref_len(m_pc);
        hs++;
      end
      if (bus.jump_en) m_pc = bus.jump_addr;
      prev_hold = bus.instr_valid && !bus.instr_ready && !bus.jump_en;
      prev_vals = {1'b1, bus.instr_opcode, bus.instr_operand, bus.instr_pc};
    end
    chk("rnd_progress", hs >= 150, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
